// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver feeding the CoCo key matrix: frames bytes, tracks
// make/break and E0 prefixes, and holds the last pressed mapped key plus Shift state.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] key_code,
    output logic       scan_strobe,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [2:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    frame_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    scan_byte_reg;
    state_t        state_reg, state_next;
    logic [5:0]    key_reg, key_next;
    logic          lshift_reg, lshift_next;
    logic          rshift_reg, rshift_next;
    logic          is_make, is_break, is_ext;
    logic [6:0]    mapped;

    // Extra stage on the clock path gives the previous value for edge detection
    // while keeping data at the same synchronizer depth.
    logic fall, data_bit;
    assign fall     = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign data_bit = data_sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
            bit_cnt_reg   <= 4'd0;
            frame_reg     <= 10'd0;
            timer_reg     <= '0;
            scan_byte_reg <= 8'd0;
            scan_strobe   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            scan_strobe   <= 1'b0;
            frame_err     <= 1'b0;
            if (fall) begin
                timer_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= 4'd0;
                    // frame_reg: [0]=start, [8:1]=data, [9]=parity; data_bit is stop
                    if (!frame_reg[0] && data_bit && (^frame_reg[9:1])) begin
                        scan_strobe   <= 1'b1;
                        scan_byte_reg <= frame_reg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    frame_reg   <= {data_bit, frame_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt_reg <= 4'd0;
                    timer_reg   <= '0;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end else begin
                timer_reg <= '0;
            end
        end
    end

    // Returns {hit, col[2:0], row[2:0]}.
    function automatic logic [6:0] map_key(input logic [7:0] code, input logic ext);
        logic [6:0] r;
        r = 7'h00;
        if (ext) begin
            case (code)
                8'h75: r = {1'b1, 6'h1B};
                8'h72: r = {1'b1, 6'h23};
                8'h6B: r = {1'b1, 6'h2B};
                8'h74: r = {1'b1, 6'h33};
                8'h6C: r = {1'b1, 6'h0E};
                default: r = 7'h00;
            endcase
        end else begin
            case (code)
                8'h54: r = {1'b1, 6'h00}; 8'h1C: r = {1'b1, 6'h08};
                8'h32: r = {1'b1, 6'h10}; 8'h21: r = {1'b1, 6'h18};
                8'h23: r = {1'b1, 6'h20}; 8'h24: r = {1'b1, 6'h28};
                8'h2B: r = {1'b1, 6'h30}; 8'h34: r = {1'b1, 6'h38};
                8'h33: r = {1'b1, 6'h01}; 8'h43: r = {1'b1, 6'h09};
                8'h3B: r = {1'b1, 6'h11}; 8'h42: r = {1'b1, 6'h19};
                8'h4B: r = {1'b1, 6'h21}; 8'h3A: r = {1'b1, 6'h29};
                8'h31: r = {1'b1, 6'h31}; 8'h44: r = {1'b1, 6'h39};
                8'h4D: r = {1'b1, 6'h02}; 8'h15: r = {1'b1, 6'h0A};
                8'h2D: r = {1'b1, 6'h12}; 8'h1B: r = {1'b1, 6'h1A};
                8'h2C: r = {1'b1, 6'h22}; 8'h3C: r = {1'b1, 6'h2A};
                8'h2A: r = {1'b1, 6'h32}; 8'h1D: r = {1'b1, 6'h3A};
                8'h22: r = {1'b1, 6'h03}; 8'h35: r = {1'b1, 6'h0B};
                8'h1A: r = {1'b1, 6'h13}; 8'h66: r = {1'b1, 6'h2B};
                8'h29: r = {1'b1, 6'h3B};
                8'h45: r = {1'b1, 6'h04}; 8'h16: r = {1'b1, 6'h0C};
                8'h1E: r = {1'b1, 6'h14}; 8'h26: r = {1'b1, 6'h1C};
                8'h25: r = {1'b1, 6'h24}; 8'h2E: r = {1'b1, 6'h2C};
                8'h36: r = {1'b1, 6'h34}; 8'h3D: r = {1'b1, 6'h3C};
                8'h3E: r = {1'b1, 6'h05}; 8'h46: r = {1'b1, 6'h0D};
                8'h52: r = {1'b1, 6'h15}; 8'h4C: r = {1'b1, 6'h1D};
                8'h41: r = {1'b1, 6'h25}; 8'h4E: r = {1'b1, 6'h2D};
                8'h49: r = {1'b1, 6'h35}; 8'h4A: r = {1'b1, 6'h3D};
                8'h5A: r = {1'b1, 6'h06}; 8'h76: r = {1'b1, 6'h16};
                8'h11: r = {1'b1, 6'h1E}; 8'h14: r = {1'b1, 6'h26};
                8'h05: r = {1'b1, 6'h2E}; 8'h06: r = {1'b1, 6'h36};
                default: r = 7'h00;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_next  = state_reg;
        key_next    = key_reg;
        lshift_next = lshift_reg;
        rshift_next = rshift_reg;
        is_make     = 1'b0;
        is_break    = 1'b0;
        is_ext      = 1'b0;
        if (scan_strobe) begin
            case (state_reg)
                IDLE: begin
                    if (scan_byte_reg == 8'hF0)      state_next = BRK;
                    else if (scan_byte_reg == 8'hE0) state_next = EXT;
                    else if (!(scan_byte_reg inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00}))
                        is_make = 1'b1;
                end
                EXT: begin
                    if (scan_byte_reg == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else begin
                        is_make    = 1'b1;
                        is_ext     = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    is_break   = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    is_break   = 1'b1;
                    is_ext     = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
        mapped = map_key(scan_byte_reg, is_ext);
        if (is_make) begin
            if (mapped[6]) key_next = mapped[5:0];
            if (!is_ext && scan_byte_reg == 8'h12) lshift_next = 1'b1;
            if (!is_ext && scan_byte_reg == 8'h59) rshift_next = 1'b1;
        end
        if (is_break) begin
            // Only releasing the currently held key clears the matrix position.
            if (mapped[6] && mapped[5:0] == key_reg) key_next = 6'h07;
            if (!is_ext && scan_byte_reg == 8'h12) lshift_next = 1'b0;
            if (!is_ext && scan_byte_reg == 8'h59) rshift_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            key_reg    <= 6'h3F;
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            key_reg    <= key_next;
            lshift_reg <= lshift_next;
            rshift_reg <= rshift_next;
        end
    end

    assign key_code = {~(lshift_reg | rshift_reg), key_reg};
endmodule
